// File: rtl/rhs2116_link_supervisor.sv
`timescale 1ns/1ps
// rhs2116_link_supervisor
//
// Bring-up and recovery controller for the RHS2116 coax receive path. It
// holds the link decoder in reset for a fixed time. It then waits for CDR lock
// and for a run of clean frames before it declares the link up. While the link
// is up it watches lock, sync and the frame-error rate, and it retrains when
// any of them goes bad. Repeated failed attempts park the block in FAULT
// until software clears it.
//
// Ports (all in the clk_sys domain unless noted):
//   clk_sys          system clock
//   rst              synchronous active-high reset
//   enable           1 = run the link, 0 = hold the decoder in reset
//   clear_fault      single-cycle pulse that leaves FAULT
//   cdr_locked_async CDR lock from the clk_link domain (asynchronous)
//   frame_error      frame-sync error pulse
//   sync_lost        frame-sync loss level
//   data_valid       decoded-word strobe
//   link_rst         active-high reset to the decoder
//   link_up          high exactly while in UP
//   fault            high exactly while in FAULT
//   state            IDLE=0 RESET=1 WAIT_LOCK=2 WAIT_FRAMES=3 UP=4 FAULT=5
//   retry_cnt        failed attempts since the last UP entry
//   frame_err_total  saturating count of frame errors seen with link_rst low
//   relock_total     saturating count of retrains out of UP
module rhs2116_link_supervisor #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int GOOD_FRAMES   = 8,
    parameter int FRAME_TIMEOUT = 65535,
    parameter int ERR_WINDOW    = 1024,
    parameter int ERR_THRESH    = 4,
    parameter int MAX_RETRIES   = 3,
    parameter int CNT_W         = 16
) (
    input  logic                             clk_sys,
    input  logic                             rst,
    input  logic                             enable,
    input  logic                             clear_fault,
    input  logic                             cdr_locked_async,
    input  logic                             frame_error,
    input  logic                             sync_lost,
    input  logic                             data_valid,
    output logic                             link_rst,
    output logic                             link_up,
    output logic                             fault,
    output logic [2:0]                       state,
    output logic [$clog2(MAX_RETRIES+1)-1:0] retry_cnt,
    output logic [CNT_W-1:0]                 frame_err_total,
    output logic [CNT_W-1:0]                 relock_total
);

    // One shared timer serves every timed state, so it is sized for the longest.
    localparam int TMR_MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int TMR_MAX_B = (FRAME_TIMEOUT > ERR_WINDOW) ? FRAME_TIMEOUT : ERR_WINDOW;
    localparam int TMR_MAX   = (TMR_MAX_A > TMR_MAX_B) ? TMR_MAX_A : TMR_MAX_B;
    localparam int TMR_W     = $clog2(TMR_MAX + 1);
    localparam int GOOD_W    = $clog2(GOOD_FRAMES + 1);
    localparam int ERR_W     = $clog2(ERR_THRESH + 1);
    localparam int RETRY_W   = $clog2(MAX_RETRIES + 1);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_RESET       = 3'd1,
        S_WAIT_LOCK   = 3'd2,
        S_WAIT_FRAMES = 3'd3,
        S_UP          = 3'd4,
        S_FAULT       = 3'd5
    } state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    logic               lock_meta_q, lock_s_q;
    state_e             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [GOOD_W-1:0]  good_q, good_d, good_inc;
    logic [ERR_W-1:0]   err_q, err_d, err_base;
    logic [ERR_W:0]     err_sum;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [CNT_W-1:0]   fet_q, fet_d, rel_q, rel_d;
    logic               link_rst_q, link_up_q, fault_q;
    logic               fail, retrain;

    // Two-flop synchronizer for the lock flag from the clk_link domain.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= cdr_locked_async;
            lock_s_q    <= lock_meta_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        good_d   = good_q;
        err_d    = err_q;
        retry_d  = retry_q;
        timer_d  = timer_q;
        fail     = 1'b0;
        retrain  = 1'b0;
        good_inc = good_q + GOOD_W'(1);
        // The first UP cycle of each window (timer at zero) starts a fresh
        // count, so an error on that cycle belongs to the new window.
        err_base = (timer_q == '0) ? '0 : err_q;
        err_sum  = {1'b0, err_base} + {{ERR_W{1'b0}}, frame_error};

        if (!enable && (state_q != S_FAULT)) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_RESET;
                S_RESET: begin
                    if (timer_q == TMR_W'(RST_CYCLES - 1)) state_d = S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    if (lock_s_q) state_d = S_WAIT_FRAMES;
                    else if (timer_q == TMR_W'(LOCK_TIMEOUT - 1)) fail = 1'b1;
                end
                S_WAIT_FRAMES: begin
                    if (!lock_s_q || sync_lost) begin
                        fail = 1'b1;
                    end else begin
                        if (frame_error) good_d = '0;
                        else if (data_valid) good_d = good_inc;
                        if (!frame_error && data_valid && (good_inc == GOOD_W'(GOOD_FRAMES)))
                            state_d = S_UP;
                        else if (timer_q == TMR_W'(FRAME_TIMEOUT - 1))
                            fail = 1'b1;
                    end
                end
                S_UP: begin
                    if (!lock_s_q || sync_lost) retrain = 1'b1;
                    else if (err_sum >= (ERR_W+1)'(ERR_THRESH)) retrain = 1'b1;
                    else err_d = err_sum[ERR_W-1:0];
                    if (retrain) state_d = S_RESET;
                end
                S_FAULT: begin
                    if (clear_fault) begin
                        state_d = S_IDLE;
                        retry_d = '0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // A failed attempt either retries from RESET or gives up into FAULT.
        if (fail) begin
            retry_d = retry_q + RETRY_W'(1);
            state_d = ((int'(retry_q) + 1) == MAX_RETRIES) ? S_FAULT : S_RESET;
        end

        if ((state_d == S_UP) && (state_q != S_UP)) begin
            retry_d = '0;
            err_d   = '0;
        end
        if ((state_d == S_WAIT_FRAMES) && (state_q != S_WAIT_FRAMES)) good_d = '0;

        if ((state_d != state_q) || (state_q == S_IDLE) || (state_q == S_FAULT))
            timer_d = '0;
        else if ((state_q == S_UP) && (timer_q == TMR_W'(ERR_WINDOW - 1)))
            timer_d = '0;
        else
            timer_d = timer_q + TMR_W'(1);

        fet_d = sat_inc(fet_q, frame_error && !link_rst_q);
        rel_d = sat_inc(rel_q, retrain);
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            good_q     <= '0;
            err_q      <= '0;
            retry_q    <= '0;
            fet_q      <= '0;
            rel_q      <= '0;
            link_rst_q <= 1'b1;
            link_up_q  <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            good_q     <= good_d;
            err_q      <= err_d;
            retry_q    <= retry_d;
            fet_q      <= fet_d;
            rel_q      <= rel_d;
            // Flag outputs are decoded from the next state so they switch on
            // the same edge as state.
            link_rst_q <= (state_d == S_IDLE) || (state_d == S_RESET) || (state_d == S_FAULT);
            link_up_q  <= (state_d == S_UP);
            fault_q    <= (state_d == S_FAULT);
        end
    end

    assign state           = state_q;
    assign link_rst        = link_rst_q;
    assign link_up         = link_up_q;
    assign fault           = fault_q;
    assign retry_cnt       = retry_q;
    assign frame_err_total = fet_q;
    assign relock_total    = rel_q;

endmodule

// File: tb/tb_rhs2116_link_supervisor.sv
`timescale 1ns/1ps
module tb_rhs2116_link_supervisor;

    logic        clk_sys = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        clear_fault = 1'b0;
    logic        cdr_locked_async = 1'b0;
    logic        frame_error = 1'b0;
    logic        sync_lost = 1'b0;
    logic        data_valid = 1'b0;
    logic        link_rst, link_up, fault;
    logic [2:0]  state;
    logic [1:0]  retry_cnt;
    logic [15:0] frame_err_total, relock_total;

    int total = 0;
    int bad   = 0;
    int exp_fet = 0;
    int exp_rel = 0;

    localparam int WIN = 1024;
    localparam int THR = 4;
    localparam int ATTEMPT = 16 + 4096;

    always #5 clk_sys = ~clk_sys;

    rhs2116_link_supervisor dut (
        .clk_sys          (clk_sys),
        .rst              (rst),
        .enable           (enable),
        .clear_fault      (clear_fault),
        .cdr_locked_async (cdr_locked_async),
        .frame_error      (frame_error),
        .sync_lost        (sync_lost),
        .data_valid       (data_valid),
        .link_rst         (link_rst),
        .link_up          (link_up),
        .fault            (fault),
        .state            (state),
        .retry_cnt        (retry_cnt),
        .frame_err_total  (frame_err_total),
        .relock_total     (relock_total)
    );

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Waits (bounded) for WAIT_FRAMES, then supplies eight clean strobes with
    // random gaps; the link must be up right after the eighth.
    task automatic reach_up(input string tag);
        int n = 0;
        while (state !== 3'd3 && n < 300) begin
            tick();
            n++;
        end
        total++;
        if (state !== 3'd3) begin
            bad++;
            $display("FAIL %s_wait_frames: state=%0d want 3", tag, state);
        end
        for (int k = 1; k <= 8; k++) begin
            repeat ($urandom_range(0, 3)) tick();
            data_valid = 1'b1;
            tick();
            data_valid = 1'b0;
            total++;
            if (state !== ((k == 8) ? 3'd4 : 3'd3)) begin
                bad++;
                $display("FAIL %s_strobe%0d: state=%0d want %0d", tag, k, state, (k == 8) ? 4 : 3);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        enable = 1'($urandom_range(0, 1));
        cdr_locked_async = 1'($urandom_range(0, 1));
        frame_error = 1'($urandom_range(0, 1));
        tick();
        tick();
        total++;
        if (link_rst !== 1'b1 || link_up !== 1'b0 || fault !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags: rst=%b up=%b fault=%b want 1 0 0", link_rst, link_up, fault);
        end
        total++;
        if (state !== 3'd0 || retry_cnt !== 2'd0) begin
            bad++;
            $display("FAIL reset_state: state=%0d retry=%0d want 0 0", state, retry_cnt);
        end
        total++;
        if (frame_err_total !== 16'd0 || relock_total !== 16'd0) begin
            bad++;
            $display("FAIL reset_totals: fet=%0d rel=%0d want 0 0", frame_err_total, relock_total);
        end
        rst = 1'b0;
        enable = 1'b0;
        cdr_locked_async = 1'b0;
        frame_error = 1'b0;
        tick();
        total++;
        if (state !== 3'd0) begin
            bad++;
            $display("FAIL idle_hold: state=%0d want 0", state);
        end
    endtask

    task automatic test_bringup();
        enable = 1'b1;
        tick();
        for (int i = 1; i <= 16; i++) begin
            total++;
            if (state !== 3'd1 || link_rst !== 1'b1) begin
                bad++;
                $display("FAIL bringup_reset%0d: state=%0d link_rst=%b want 1 1", i, state, link_rst);
            end
            // Monitor inputs are ignored in RESET, and frame errors do not
            // count while link_rst is high.
            frame_error = 1'($urandom_range(0, 1));
            sync_lost   = 1'($urandom_range(0, 1));
            data_valid  = 1'($urandom_range(0, 1));
            tick();
        end
        frame_error = 1'b0;
        sync_lost = 1'b0;
        data_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            total++;
            if (state !== 3'd2 || link_rst !== 1'b0) begin
                bad++;
                $display("FAIL bringup_wait_lock%0d: state=%0d link_rst=%b want 2 0", i, state, link_rst);
            end
            tick();
        end
        cdr_locked_async = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            total++;
            if (state !== ((i == 3) ? 3'd3 : 3'd2)) begin
                bad++;
                $display("FAIL bringup_lock_lat%0d: state=%0d want %0d", i, state, (i == 3) ? 3 : 2);
            end
        end
        for (int k = 1; k <= 8; k++) begin
            repeat ($urandom_range(0, 3)) begin
                tick();
                total++;
                if (state !== 3'd3) begin
                    bad++;
                    $display("FAIL bringup_gap: state=%0d want 3", state);
                end
            end
            data_valid = 1'b1;
            tick();
            data_valid = 1'b0;
            total++;
            if (link_up !== (k == 8) || state !== ((k == 8) ? 3'd4 : 3'd3)) begin
                bad++;
                $display("FAIL bringup_strobe%0d: state=%0d up=%b", k, state, link_up);
            end
        end
        total++;
        if (retry_cnt !== 2'd0 || link_rst !== 1'b0 || fault !== 1'b0 || frame_err_total !== 16'(exp_fet)) begin
            bad++;
            $display("FAIL bringup_final: retry=%0d rst=%b fault=%b fet=%0d want 0 0 0 %0d",
                     retry_cnt, link_rst, fault, frame_err_total, exp_fet);
        end
    endtask

    task automatic test_qual_restart();
        enable = 1'b0;
        tick();
        enable = 1'b1;
        reach_up_prefix();
        for (int k = 1; k <= 5; k++) begin
            repeat ($urandom_range(0, 2)) tick();
            data_valid = 1'b1;
            tick();
            data_valid = 1'b0;
        end
        frame_error = 1'b1;
        data_valid = 1'($urandom_range(0, 1));
        tick();
        frame_error = 1'b0;
        data_valid = 1'b0;
        exp_fet++;
        total++;
        if (state !== 3'd3) begin
            bad++;
            $display("FAIL qual_after_error: state=%0d want 3", state);
        end
        for (int k = 1; k <= 8; k++) begin
            repeat ($urandom_range(0, 2)) tick();
            data_valid = 1'b1;
            tick();
            data_valid = 1'b0;
            total++;
            if (state !== ((k == 8) ? 3'd4 : 3'd3)) begin
                bad++;
                $display("FAIL qual_strobe%0d: state=%0d want %0d", k, state, (k == 8) ? 4 : 3);
            end
        end
        total++;
        if (frame_err_total !== 16'(exp_fet)) begin
            bad++;
            $display("FAIL qual_fet: fet=%0d want %0d", frame_err_total, exp_fet);
        end
    endtask

    // Bounded wait for WAIT_FRAMES only.
    task automatic reach_up_prefix();
        int n = 0;
        while (state !== 3'd3 && n < 300) begin
            tick();
            n++;
        end
        total++;
        if (state !== 3'd3) begin
            bad++;
            $display("FAIL prefix_wait_frames: state=%0d want 3", state);
        end
    endtask

    // Error pulses at given offsets from UP entry; the expected state comes
    // from per-window counts (window = offset / WIN).
    task automatic run_err_pattern(input string tag, input int pos[], input int npos);
        int wc[8];
        int u = 0;
        bit tripped = 0;
        for (int w = 0; w < 8; w++) wc[w] = 0;
        for (int j = 0; j < npos && !tripped; j++) begin
            while (u < pos[j]) begin
                tick();
                u++;
            end
            total++;
            if (state !== 3'd4) begin
                bad++;
                $display("FAIL %s_pre%0d: state=%0d want 4 at u=%0d", tag, j, state, u);
            end
            wc[u / WIN]++;
            tripped = (wc[u / WIN] >= THR);
            frame_error = 1'b1;
            tick();
            frame_error = 1'b0;
            u++;
            exp_fet++;
            if (tripped) exp_rel++;
            total++;
            if (state !== (tripped ? 3'd1 : 3'd4)) begin
                bad++;
                $display("FAIL %s_post%0d: state=%0d want %0d", tag, j, state, tripped ? 1 : 4);
            end
        end
        total++;
        if (relock_total !== 16'(exp_rel) || frame_err_total !== 16'(exp_fet)) begin
            bad++;
            $display("FAIL %s_totals: rel=%0d fet=%0d want %0d %0d", tag, relock_total, frame_err_total, exp_rel, exp_fet);
        end
    endtask

    task automatic test_err_thresh();
        int p[];
        p = new[4];
        p[0] = $urandom_range(0, 100);
        for (int j = 1; j < 4; j++) p[j] = p[j-1] + $urandom_range(1, 200);
        run_err_pattern("thresh", p, 4);
        reach_up("thresh_rearm");
        p = new[6];
        p[0] = $urandom_range(0, 500);
        p[1] = $urandom_range(p[0] + 1, 1022);
        p[2] = 1023;
        p[3] = 1024;
        p[4] = $urandom_range(1025, 1500);
        p[5] = $urandom_range(p[4] + 1, 2000);
        run_err_pattern("window", p, 6);
        repeat (60) tick();
        total++;
        if (state !== 3'd4 || link_up !== 1'b1) begin
            bad++;
            $display("FAIL window_hold: state=%0d up=%b want 4 1", state, link_up);
        end
    endtask

    task automatic test_loss_up();
        sync_lost = 1'b1;
        tick();
        sync_lost = 1'b0;
        exp_rel++;
        total++;
        if (state !== 3'd1 || link_rst !== 1'b1 || link_up !== 1'b0 || relock_total !== 16'(exp_rel)) begin
            bad++;
            $display("FAIL loss_sync: state=%0d rst=%b up=%b rel=%0d want 1 1 0 %0d",
                     state, link_rst, link_up, relock_total, exp_rel);
        end
        reach_up_prefix();
        sync_lost = 1'b1;
        tick();
        sync_lost = 1'b0;
        total++;
        if (state !== 3'd1 || retry_cnt !== 2'd1 || relock_total !== 16'(exp_rel)) begin
            bad++;
            $display("FAIL loss_wait_frames: state=%0d retry=%0d rel=%0d want 1 1 %0d",
                     state, retry_cnt, relock_total, exp_rel);
        end
        reach_up("loss_rearm");
        total++;
        if (retry_cnt !== 2'd0) begin
            bad++;
            $display("FAIL loss_retry_clear: retry=%0d want 0", retry_cnt);
        end
        cdr_locked_async = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            total++;
            if (state !== ((i == 3) ? 3'd1 : 3'd4)) begin
                bad++;
                $display("FAIL loss_lock%0d: state=%0d want %0d", i, state, (i == 3) ? 1 : 4);
            end
        end
        exp_rel++;
        total++;
        if (relock_total !== 16'(exp_rel)) begin
            bad++;
            $display("FAIL loss_lock_rel: rel=%0d want %0d", relock_total, exp_rel);
        end
        cdr_locked_async = 1'b1;
        reach_up("loss_final");
    endtask

    task automatic test_enable();
        enable = 1'b0;
        tick();
        enable = 1'b1;
        reach_up_prefix();
        enable = 1'b0;
        tick();
        total++;
        if (state !== 3'd0 || link_rst !== 1'b1) begin
            bad++;
            $display("FAIL enable_drop: state=%0d rst=%b want 0 1", state, link_rst);
        end
        frame_error = 1'b1;
        tick();
        tick();
        frame_error = 1'b0;
        tick();
        total++;
        if (state !== 3'd0 || frame_err_total !== 16'(exp_fet)) begin
            bad++;
            $display("FAIL enable_idle_err: state=%0d fet=%0d want 0 %0d", state, frame_err_total, exp_fet);
        end
    endtask

    task automatic test_reset_mid();
        enable = 1'b1;
        reach_up("rstmid");
        rst = 1'b1;
        tick();
        total++;
        if (state !== 3'd0 || link_rst !== 1'b1 || link_up !== 1'b0 || fault !== 1'b0 || retry_cnt !== 2'd0 ||
            frame_err_total !== 16'd0 || relock_total !== 16'd0) begin
            bad++;
            $display("FAIL rstmid: state=%0d rst=%b up=%b fault=%b retry=%0d fet=%0d rel=%0d want reset values",
                     state, link_rst, link_up, fault, retry_cnt, frame_err_total, relock_total);
        end
        exp_fet = 0;
        exp_rel = 0;
        rst = 1'b0;
        enable = 1'b0;
        cdr_locked_async = 1'b0;
    endtask

    task automatic test_lock_timeout();
        int clr_at;
        int a, r;
        logic [2:0] es;
        logic [1:0] er;
        repeat (3) tick();
        clr_at = ATTEMPT + $urandom_range(100, 4000);
        enable = 1'b1;
        for (int n = 1; n <= 3 * ATTEMPT + 6; n++) begin
            tick();
            clear_fault = 1'b0;
            a = (n - 1) / ATTEMPT;
            r = (n - 1) % ATTEMPT;
            es = (a >= 3) ? 3'd5 : ((r < 16) ? 3'd1 : 3'd2);
            er = 2'((a >= 3) ? 3 : a);
            total++;
            if (state !== es || retry_cnt !== er || link_rst !== (es != 3'd2)) begin
                bad++;
                $display("FAIL timeout_n%0d: state=%0d retry=%0d rst=%b want %0d %0d", n, state, retry_cnt, link_rst, es, er);
            end
            if (n == clr_at) clear_fault = 1'b1;
            if (a >= 3) begin
                enable = 1'($urandom_range(0, 1));
                frame_error = 1'($urandom_range(0, 1));
            end
        end
        frame_error = 1'b0;
        total++;
        if (fault !== 1'b1 || frame_err_total !== 16'(exp_fet)) begin
            bad++;
            $display("FAIL timeout_fault: fault=%b fet=%0d want 1 %0d", fault, frame_err_total, exp_fet);
        end
        enable = 1'b0;
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        total++;
        if (state !== 3'd0 || retry_cnt !== 2'd0 || fault !== 1'b0 || link_rst !== 1'b1) begin
            bad++;
            $display("FAIL timeout_clear: state=%0d retry=%0d fault=%b rst=%b want 0 0 0 1",
                     state, retry_cnt, fault, link_rst);
        end
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_qual_restart();
        test_err_thresh();
        test_loss_up();
        test_enable();
        test_reset_mid();
        test_lock_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
